// File: rtl/letreiro_prog.sv
// Programmable N-lamp sign sequencer: a writable pattern table played back at a
// programmable dwell rate in loop, one-shot, blink or hold mode.
module letreiro_prog #(
  parameter int CANAIS = 3,
  parameter int PASSOS = 16,
  parameter int DIV_W  = 8,
  localparam int AW    = $clog2(PASSOS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [CANAIS-1:0] wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic              enable,
  input  logic [1:0]        modo,
  input  logic [AW-1:0]     ultimo,
  input  logic [DIV_W-1:0]  divisor,
  output logic [CANAIS-1:0] palavras,
  output logic [AW-1:0]     passo,
  output logic              fim,
  output logic              ocupado
);

  localparam logic [1:0] OCIOSO    = 2'd0;
  localparam logic [1:0] RODANDO   = 2'd1;
  localparam logic [1:0] CONCLUIDO = 2'd2;

  localparam logic [1:0] M_LOOP    = 2'b00;
  localparam logic [1:0] M_ONESHOT = 2'b01;
  localparam logic [1:0] M_BLINK   = 2'b10;
  localparam logic [1:0] M_HOLD    = 2'b11;

  logic [CANAIS-1:0] mem [PASSOS];

  logic [1:0]       estado;
  logic [DIV_W-1:0] dwell;
  logic [DIV_W-1:0] divisor_l;
  logic [AW-1:0]    ultimo_l;
  logic [1:0]       modo_l;
  logic             fase;

  logic             avanca;
  logic             dwell_fim;
  logic             wrap;
  logic [AW-1:0]    passo_alvo;

  // NOTE: the pattern table has no reset; its contents survive reset by design,
  // and keeping it out of the reset domain lets it map onto plain RAM.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which is what keeps this block free of inferred latches.
  always_comb begin
    avanca     = 1'b0;
    dwell_fim  = 1'b0;
    wrap       = 1'b0;
    passo_alvo = '0;
    avanca     = (estado == RODANDO) && enable && (modo_l != M_HOLD);
    dwell_fim  = (dwell == divisor_l);
    wrap       = !(passo < ultimo_l);
    passo_alvo = wrap ? '0 : passo + AW'(1);
  end

  // NOTE: state is written with non-blocking assignments so every read in this
  // block sees the pre-edge value, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= OCIOSO;
      passo     <= '0;
      dwell     <= '0;
      fase      <= 1'b1;
      palavras  <= '0;
      fim       <= 1'b0;
      modo_l    <= M_LOOP;
      ultimo_l  <= '0;
      divisor_l <= '0;
    end else begin
      fim <= 1'b0;
      if (stop) begin
        estado   <= OCIOSO;
        passo    <= '0;
        dwell    <= '0;
        fase     <= 1'b1;
        palavras <= '0;
      end else if (start) begin
        estado    <= RODANDO;
        passo     <= '0;
        dwell     <= '0;
        fase      <= 1'b1;
        palavras  <= mem[0];
        modo_l    <= modo;
        ultimo_l  <= ultimo;
        divisor_l <= divisor;
      end else if (avanca) begin
        if (!dwell_fim) begin
          dwell <= dwell + DIV_W'(1);
        end else begin
          dwell <= '0;
          case (modo_l)
            M_ONESHOT: begin
              if (wrap) begin
                estado <= CONCLUIDO;
                fim    <= 1'b1;
              end else begin
                passo    <= passo_alvo;
                palavras <= mem[passo_alvo];
              end
            end
            M_BLINK: begin
              // Dark half-period keeps passo on the step just shown; the
              // advance happens when the lamps come back on.
              if (fase) begin
                fase     <= 1'b0;
                palavras <= '0;
              end else begin
                fase     <= 1'b1;
                passo    <= passo_alvo;
                palavras <= mem[passo_alvo];
                fim      <= wrap;
              end
            end
            default: begin
              passo    <= passo_alvo;
              palavras <= mem[passo_alvo];
              fim      <= wrap;
            end
          endcase
        end
      end
    end
  end

  assign ocupado = (estado == RODANDO);

endmodule

// File: tb/tb_letreiro_prog.sv
// Directed, table-driven bench for letreiro_prog: each record drives one clock
// and lists the outputs expected right after that edge.
module tb_letreiro_prog;

  logic       clock = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [2:0] wr_data;
  logic       start, stop, enable;
  logic [1:0] modo;
  logic [3:0] ultimo;
  logic [7:0] divisor;
  logic [2:0] palavras;
  logic [3:0] passo;
  logic       fim, ocupado;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       st, sp, en, we;
    logic [3:0] wa;
    logic [2:0] wd;
    logic [2:0] pal;
    logic [3:0] ps;
    logic       fim, oc;
  } vec_t;

  vec_t vq[$];

  logic [2:0] legacy [10] = '{3'b000, 3'b100, 3'b110, 3'b111, 3'b100,
                              3'b011, 3'b000, 3'b111, 3'b010, 3'b001};
  logic [2:0] bp [8] = '{3'b101, 3'b101, 3'b000, 3'b000,
                         3'b010, 3'b010, 3'b000, 3'b000};
  logic [3:0] bs [8] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1};

  letreiro_prog dut (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .stop    (stop),
    .enable  (enable),
    .modo    (modo),
    .ultimo  (ultimo),
    .divisor (divisor),
    .palavras(palavras),
    .passo   (passo),
    .fim     (fim),
    .ocupado (ocupado)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [2:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  function automatic void add(input logic st, sp, en, we, input logic [3:0] wa,
                              input logic [2:0] wd, pal, input logic [3:0] ps,
                              input logic f, oc);
    vq.push_back('{st, sp, en, we, wa, wd, pal, ps, f, oc});
  endfunction

  // Plain running cycle: enable high, no commands, no writes.
  function automatic void run(input logic [2:0] pal, input logic [3:0] ps, input logic f);
    add(0, 0, 1, 0, 4'd0, 3'd0, pal, ps, f, 1);
  endfunction

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      start = vq[i].st; stop = vq[i].sp; enable = vq[i].en;
      wr_en = vq[i].we; wr_addr = vq[i].wa; wr_data = vq[i].wd;
      tick();
      start = 1'b0; stop = 1'b0; wr_en = 1'b0;
      check($sformatf("%s[%0d].palavras", tag, i), palavras, vq[i].pal);
      check($sformatf("%s[%0d].passo", tag, i), passo, vq[i].ps);
      check($sformatf("%s[%0d].fim", tag, i), fim, vq[i].fim);
      check($sformatf("%s[%0d].ocupado", tag, i), ocupado, vq[i].oc);
    end
    vq.delete();
  endtask

  task automatic cfg(input logic [1:0] m, input logic [3:0] u, input logic [7:0] d);
    modo = m; ultimo = u; divisor = d;
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; stop = 1'b0; enable = 1'b1;
    modo = 2'b00; ultimo = '0; divisor = '0;

    tick(); tick();
    check("rst.palavras", palavras, 0);
    check("rst.passo", passo, 0);
    check("rst.fim", fim, 0);
    check("rst.ocupado", ocupado, 0);
    reset = 1'b1;
    tick(); tick(); tick();
    check("idle.palavras", palavras, 0);
    check("idle.ocupado", ocupado, 0);

    for (int i = 0; i < 10; i++) wr(4'(i), legacy[i]);

    // Legacy three-word sign, one entry per cycle, wrapping 9 -> 0.
    cfg(2'b00, 4'd9, 8'd0);
    add(1, 0, 1, 0, 4'd0, 3'd0, legacy[0], 4'd0, 0, 1);
    for (int k = 1; k < 24; k++) run(legacy[k % 10], 4'(k % 10), (k % 10) == 0);
    run_vecs("loop");

    // Asynchronous reset mid-run, sampled with no clock edge in between.
    reset = 1'b0;
    #2;
    check("async_rst.palavras", palavras, 0);
    check("async_rst.passo", passo, 0);
    check("async_rst.fim", fim, 0);
    check("async_rst.ocupado", ocupado, 0);
    #2;
    reset = 1'b1;
    tick(); tick(); tick();
    check("post_rst.palavras", palavras, 0);
    check("post_rst.ocupado", ocupado, 0);
    check("post_rst.passo", passo, 0);

    // Table survives reset.
    add(1, 0, 1, 0, 4'd0, 3'd0, legacy[0], 4'd0, 0, 1);
    for (int k = 1; k < 4; k++) run(legacy[k], 4'(k), 0);
    run_vecs("retain");

    // One-shot, 4-cycle dwell, ends in CONCLUIDO on the last entry.
    cfg(2'b01, 4'd2, 8'd3);
    add(1, 0, 1, 0, 4'd0, 3'd0, legacy[0], 4'd0, 0, 1);
    for (int k = 1; k < 12; k++) run(legacy[k / 4], 4'(k / 4), 0);
    add(0, 0, 1, 0, 4'd0, 3'd0, legacy[2], 4'd2, 1, 0);
    add(0, 0, 1, 0, 4'd0, 3'd0, legacy[2], 4'd2, 0, 0);
    add(0, 0, 1, 0, 4'd0, 3'd0, legacy[2], 4'd2, 0, 0);
    run_vecs("oneshot");

    // Blink: on/off half-periods of divisor+1 cycles, started from CONCLUIDO.
    wr(4'd0, 3'b101);
    wr(4'd1, 3'b010);
    cfg(2'b10, 4'd1, 8'd1);
    add(1, 0, 1, 0, 4'd0, 3'd0, bp[0], bs[0], 0, 1);
    for (int k = 1; k < 18; k++) run(bp[k % 8], bs[k % 8], (k % 8) == 0);
    run_vecs("blink");

    // Pause mid-dwell keeps the remaining dwell; start+stop together idles.
    wr(4'd2, 3'b110);
    cfg(2'b00, 4'd2, 8'd3);
    add(1, 0, 1, 0, 4'd0, 3'd0, 3'b101, 4'd0, 0, 1);
    run(3'b101, 4'd0, 0);
    run(3'b101, 4'd0, 0);
    for (int k = 0; k < 5; k++) add(0, 0, 0, 0, 4'd0, 3'd0, 3'b101, 4'd0, 0, 1);
    run(3'b101, 4'd0, 0);
    run(3'b010, 4'd1, 0);
    run(3'b010, 4'd1, 0);
    add(1, 1, 1, 0, 4'd0, 3'd0, 3'b000, 4'd0, 0, 0);
    add(0, 0, 1, 0, 4'd0, 3'd0, 3'b000, 4'd0, 0, 0);
    add(0, 0, 1, 0, 4'd0, 3'd0, 3'b000, 4'd0, 0, 0);
    run_vecs("pause");

    // Single-step table: every step event is a wrap.
    cfg(2'b00, 4'd0, 8'd2);
    add(1, 0, 1, 0, 4'd0, 3'd0, 3'b101, 4'd0, 0, 1);
    for (int k = 1; k < 9; k++) run(3'b101, 4'd0, (k % 3) == 0);
    run_vecs("ultimo0");

    // Hold mode: step 0 forever, no fim, then stop.
    cfg(2'b11, 4'd2, 8'd0);
    add(1, 0, 1, 0, 4'd0, 3'd0, 3'b101, 4'd0, 0, 1);
    for (int k = 1; k < 6; k++) run(3'b101, 4'd0, 0);
    add(0, 1, 1, 0, 4'd0, 3'd0, 3'b000, 4'd0, 0, 0);
    run_vecs("hold");

    // Writes during run: current step and step-entry collision both show old data.
    cfg(2'b00, 4'd2, 8'd3);
    add(1, 0, 1, 0, 4'd0, 3'd0, 3'b101, 4'd0, 0, 1);
    add(0, 0, 1, 1, 4'd0, 3'b111, 3'b101, 4'd0, 0, 1);
    run(3'b101, 4'd0, 0);
    run(3'b101, 4'd0, 0);
    for (int k = 4; k < 8; k++) run(3'b010, 4'd1, 0);
    add(0, 0, 1, 1, 4'd2, 3'b001, 3'b110, 4'd2, 0, 1);
    for (int k = 9; k < 12; k++) run(3'b110, 4'd2, 0);
    run(3'b111, 4'd0, 1);
    for (int k = 13; k < 16; k++) run(3'b111, 4'd0, 0);
    for (int k = 16; k < 20; k++) run(3'b010, 4'd1, 0);
    run(3'b001, 4'd2, 0);
    run(3'b001, 4'd2, 0);
    run_vecs("write_run");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/letreiro_prog.md
Name: letreiro_prog

Overview:
Programmable N-lamp sign sequencer, the parametrised successor of the fixed 3-word sign. It stores a writable pattern table and steps through it at a programmable dwell rate. It supports loop, one-shot, blink and hold modes, with start/stop control and an end-of-sequence pulse. It sits between the panel controller, which writes the pattern and issues commands, and the lamp drivers.

Parameters:
CANAIS, 3, number of lamp/word outputs (width of each pattern entry)
PASSOS, 16, pattern table depth (max steps), power of two, >=2
DIV_W, 8, width of the dwell divisor
Derived: AW = $clog2(PASSOS)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
wr_en  in  1  pattern table write strobe
wr_addr  in  AW  table write index
wr_data  in  CANAIS  table write data
start  in  1  1-cycle command: begin sequence at step 0
stop  in  1  1-cycle command: abort to idle
enable  in  1  1 = counters advance; 0 = freeze (pause)
modo  in  2  00 loop, 01 one-shot, 10 blink-loop, 11 hold-step-0
ultimo  in  AW  index of last step (length-1)
divisor  in  DIV_W  dwell length minus 1, in clock cycles
palavras  out  CANAIS  lamp outputs, registered
passo  out  AW  current step index
fim  out  1  1-cycle pulse on wrap (loop) or completion (one-shot)
ocupado  out  1  1 while in RODANDO

Behaviour:
- Reset (reset=0, async): state=OCIOSO, passo=0, dwell=0, fase=1, palavras=0, fim=0. The pattern table is not reset and holds its contents.
- Table write: on a clock edge with wr_en=1, mem[wr_addr]<=wr_data. Writes are accepted in any state.
- palavras is loaded from mem only on step entry. A write to the displayed step becomes visible at its next entry. A write and a step entry to the same index in one cycle shows the old data.
- States: OCIOSO, RODANDO, CONCLUIDO.
- start (any state, stop=0) -> RODANDO. On that edge: passo=0, dwell=0, fase=1, palavras<=mem[0]. modo, ultimo and divisor are latched at this edge. ultimo is used as is; divisor=0 means a 1-cycle dwell.
- stop=1 (any state) -> OCIOSO with palavras=0 next edge. stop has priority over start when both are asserted.
- RODANDO with enable=1: dwell increments each cycle. When dwell==divisor_l, dwell<=0 and the step event fires.
- RODANDO with enable=0: all counters and outputs hold. start and stop are still honoured.
- Step event, modes 00/01: if passo<ultimo_l, passo++ and palavras<=mem[passo+1]. Otherwise:
  - 00: passo<=0, palavras<=mem[0], fim=1 for one cycle.
  - 01: -> CONCLUIDO, palavras holds last entry, fim=1 for one cycle.
- Step event, mode 10: fase toggles.
  - Going 1->0: palavras<=0.
  - Going 0->1: advance as in mode 00 and show the new entry. fim pulses on the 0->1 wrap.
  - Each step is therefore on for (divisor+1) cycles, then off for (divisor+1) cycles.
- Mode 11: palavras=mem[0] at start and passo stays 0. No step events and no fim.
- CONCLUIDO: outputs hold; only start or stop leave it.
- ultimo_l=0: every step event is a wrap, so in mode 00 fim pulses every divisor+1 cycles.
- ocupado = (state==RODANDO). passo is 0 in OCIOSO.
- Reset asserted mid-sequence clears everything asynchronously. After release the block idles until start.

Test Plan:
- Reset/idle: hold reset=0 mid-run -> palavras=000, passo=0, fim=0, ocupado=0 immediately (no clock edge needed). After release, no activity without start.
- Loop, legacy sign: write 000,100,110,111,100,011,000,111,010,001 to entries 0..9; ultimo=9, divisor=0, modo=00, start -> palavras follows that sequence one entry per cycle. passo wraps 9->0 every 10 cycles, with fim=1 on each wrap cycle only.
- One-shot with dwell: ultimo=2, divisor=3, modo=01 -> each entry held 4 cycles. After 12 cycles state=CONCLUIDO, palavras=mem[2], fim pulses once, ocupado=0.
- Blink: ultimo=1, divisor=1, modo=10, mem[0]=101, mem[1]=010 -> sequence 101,101,000,000,010,010,000,000, repeating. fim pulses when 101 reappears.
- Pause/priority: enable=0 for 5 cycles mid-step -> palavras and passo frozen, then resume with the remaining dwell intact. start and stop in the same cycle -> OCIOSO, palavras=000.
- Write during run: overwrite the current entry -> display unchanged until the next entry to that step, then shows the new value. Repeat with wr_addr equal to the next step on the step-event cycle -> old value shown.
